// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sharing one radix-2 shift-add / restoring-divide engine
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_op;
  logic [XLEN-1:0] r_mag2, r_fin, r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN:0] r_rem;
  logic r_nq, r_nr, r_done;
  logic w_accept, w_sgn1, w_sgn2, w_neg1, w_neg2, w_dz, w_ovf, w_special;
  logic [XLEN-1:0] w_mag1, w_mag2, w_spec_val, w_quo, w_remv, w_fix;
  logic [XLEN:0] w_msum, w_dsh;
  logic [XLEN+1:0] w_dsub;
  logic [2*XLEN-1:0] w_prod;
  assign busy   = r_state != IDLE;
  assign done   = r_done;
  assign result = r_result;
  // the cycle that shows done is already IDLE, so a start there is explicitly refused
  assign w_accept   = (r_state == IDLE) && start && !r_done;
  assign w_sgn1     = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign w_sgn2     = op[2] ? ~op[0] : ~op[1];
  assign w_neg1     = w_sgn1 & rs1_data[XLEN-1];
  assign w_neg2     = w_sgn2 & rs2_data[XLEN-1];
  assign w_mag1     = w_neg1 ? -rs1_data : rs1_data;
  assign w_mag2     = w_neg2 ? -rs2_data : rs2_data;
  assign w_dz       = op[2] & (rs2_data == '0);
  assign w_ovf      = op[2] & ~op[0] & (rs1_data == MIN) & (&rs2_data);
  assign w_special  = w_dz | w_ovf;
  assign w_spec_val = w_dz ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : MIN);
  // multiply: multiplier sits in the low half and shifts out, multiplicand is added into the high half
  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag2} : '0);
  // divide: dividend shifts out of the low half MSB first while quotient bits enter at the LSB
  assign w_dsh  = {r_rem[XLEN-1:0], r_acc[XLEN-1]};
  assign w_dsub = {1'b0, w_dsh} - {2'b0, r_mag2};
  assign w_prod = r_nq ? -r_acc : r_acc;
  assign w_quo  = r_nq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_remv = r_nr ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_fix  = r_op[2] ? (r_op[1] ? w_remv : w_quo)
                          : (r_op == 3'b000 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next-state: special divide cases skip the iterative engine entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_special ? DONE : CALC) : IDLE;
      CALC:    w_next = (r_cnt == '0) ? FIX : CALC;
      FIX:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: operand capture, one iteration per CALC cycle, sign fix, result publish on leaving DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_mag2   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_nq     <= 1'b0;
      r_nr     <= 1'b0;
      r_fin    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= r_state == DONE;
      if (r_state == DONE) r_result <= r_fin;
      if (w_accept) begin
        r_op   <= op;
        r_cnt  <= CW'(XLEN - 1);
        r_mag2 <= w_mag2;
        r_acc  <= {{XLEN{1'b0}}, w_mag1};
        r_rem  <= '0;
        r_nq   <= w_neg1 ^ w_neg2;
        r_nr   <= w_neg1;
        r_fin  <= w_spec_val;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_op[2]) begin
          r_rem              <= w_dsub[XLEN+1] ? w_dsh : w_dsub[XLEN:0];
          r_acc[XLEN-1:0]    <= {r_acc[XLEN-2:0], ~w_dsub[XLEN+1]};
        end else begin
          r_acc <= {w_msum, r_acc[XLEN-1:1]};
        end
      end else if (r_state == FIX) begin
        r_fin <= w_fix;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic busy, done;
  logic [31:0] result;
  int n_tests = 0, n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int n, bc;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; rs1_data = ~a; rs2_data = b ^ 32'h5A5A_1234;
    n = 0; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(lat));
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_result"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int dn, lat;
    #2 rst = 1'b1;
    #3;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu_ones",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu_ones", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run("divu_100_7",  3'b101, 32'd100,        32'd7,         32'd14,        34);
    run("remu_100_7",  3'b111, 32'd100,        32'd7,         32'd2,         34);
    run("div_by0",     3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("remu_by0",    3'b111, 32'd5,          32'd0,         32'd5,         1);
    run("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // start while busy (edge 10) and during the done cycle (edge 35) must both be ignored
    @(negedge clk);
    start = 1'b1; op = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 10) || (i == 35);
      op = (i == 35) ? 3'b100 : 3'b101;
      rs1_data = 32'd9;
      rs2_data = (i == 35) ? 32'd0 : 32'd3;
      @(posedge clk); #1;
      if (done) begin dn++; lat = i; end
    end
    start = 1'b0;
    check("ignore_done_count", 32'(dn), 32'd1);
    check("ignore_latency", 32'(lat), 32'd34);
    check("ignore_result", result, 32'd100);

    // asynchronous reset mid-multiply
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs1_data = 32'd123; rs2_data = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
    run("mul_after_rst", 3'b000, 32'd6, 32'd7, 32'd42, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
